// File: rtl/uop_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : uop_sequencer
// Description : Expands one decoded instruction into 1..MAX_UOPS ordered uops
//               with ids, first/last flags and branch-queue allocation.
// Revision    : 1.0 - initial release
// ============================================================================
module uop_sequencer #(
    parameter int PW       = 64,
    parameter int MAX_UOPS = 4,
    parameter int ID_W     = 8,
    parameter int BQID_W   = 4,
    parameter int UIW      = $clog2(MAX_UOPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PW-1:0]     in_payload,
    input  logic [UIW:0]      in_nuops,
    input  logic              in_has_branch,
    input  logic [UIW-1:0]    in_branch_uop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PW-1:0]     out_payload,
    output logic [UIW-1:0]    out_uop_idx,
    output logic              out_is_uop,
    output logic              out_is_uop_last,
    output logic [ID_W-1:0]   out_id,
    output logic [BQID_W-1:0] out_bqid,
    output logic              bq_push_valid,
    input  logic              bq_push_ready,
    input  logic [BQID_W-1:0] bq_bqid,
    output logic [ID_W-1:0]   bq_push_id,
    input  logic              squash_valid,
    input  logic [ID_W-1:0]   squash_id
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEQ  = 1'b1
    } state_t;

    localparam logic [UIW:0] c_max_nuops = (UIW+1)'(MAX_UOPS);
    localparam logic [UIW:0] c_one_nuop  = (UIW+1)'(1);

    state_t              r_state;
    state_t              w_state_next;
    logic [PW-1:0]       r_payload;
    logic [UIW:0]        r_nuops;
    logic                r_has_branch;
    logic [UIW-1:0]      r_branch_uop;
    logic [UIW-1:0]      r_cnt;
    logic [ID_W-1:0]     r_id;

    logic                w_busy;
    logic                w_last;
    logic                w_is_br_uop;
    logic                w_is_multi;
    logic                w_out_valid;
    logic                w_fire;
    logic                w_in_ready;
    logic                w_accept;
    logic [UIW:0]        w_nuops_eff;

    assign w_busy      = (r_state == S_SEQ);
    assign w_last      = ({1'b0, r_cnt} == (r_nuops - c_one_nuop));
    assign w_is_br_uop = r_has_branch && (r_cnt == r_branch_uop);
    assign w_is_multi  = (r_nuops > c_one_nuop);

    // A branch uop may only leave once the branch queue can take its entry.
    assign w_out_valid = !rst && !squash_valid && w_busy && !(w_is_br_uop && !bq_push_ready);
    assign w_fire      = w_out_valid && out_ready;
    assign w_in_ready  = !rst && !squash_valid && (!w_busy || (w_fire && w_last));
    assign w_accept    = in_valid && w_in_ready;

    always_comb begin
        w_nuops_eff = in_nuops;
        if (in_nuops == '0) begin
            w_nuops_eff = c_one_nuop;
        end else if (in_nuops > c_max_nuops) begin
            w_nuops_eff = c_max_nuops;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (squash_valid) begin
            w_state_next = S_IDLE;
        end else if (w_accept) begin
            w_state_next = S_SEQ;
        end else if (w_fire && w_last) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_payload    <= '0;
            r_nuops      <= '0;
            r_has_branch <= 1'b0;
            r_branch_uop <= '0;
            r_cnt        <= '0;
            r_id         <= '0;
        end else if (squash_valid) begin
            r_cnt <= '0;
            r_id  <= squash_id + 1'b1;
        end else begin
            if (w_fire) begin
                r_id <= r_id + 1'b1;
                if (!w_last) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            // Acceptance overrides the counter update of a coincident last-uop fire.
            if (w_accept) begin
                r_payload    <= in_payload;
                r_nuops      <= w_nuops_eff;
                r_has_branch <= in_has_branch;
                r_branch_uop <= in_branch_uop;
                r_cnt        <= '0;
            end
        end
    end

    assign in_ready        = w_in_ready;
    assign out_valid       = w_out_valid;
    assign out_payload     = rst ? '0 : r_payload;
    assign out_uop_idx     = rst ? '0 : r_cnt;
    assign out_is_uop      = !rst && w_is_multi;
    assign out_is_uop_last = !rst && w_is_multi && w_last;
    assign out_id          = rst ? '0 : r_id;
    assign out_bqid        = (!rst && w_busy && w_is_br_uop) ? bq_bqid : '0;
    assign bq_push_valid   = w_fire && w_is_br_uop;
    assign bq_push_id      = out_id;

endmodule
`default_nettype wire
